// File: rtl/dyna_tree_host_if.sv
// Host token streams and root TPort of dyna_tree_host.
// master = the host block (drives the tree), slave = the environment side.
interface dyna_tree_host_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_tok;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_tok;
    logic       out_last;
    logic [3:0] to_tree_msg;
    logic [1:0] to_tree_tgt;
    logic [3:0] from_tree_msg;
    logic [1:0] from_tree_tgt;

    modport master (
        input  in_valid, in_tok, in_last, out_ready, from_tree_msg, from_tree_tgt,
        output in_ready, out_valid, out_tok, out_last, to_tree_msg, to_tree_tgt
    );
    modport slave (
        output in_valid, in_tok, in_last, out_ready, from_tree_msg, from_tree_tgt,
        input  in_ready, out_valid, out_tok, out_last, to_tree_msg, to_tree_tgt
    );
endinterface

// File: rtl/dyna_tree_host.sv
// Root-port initiator for the dynamic combinator tree: clear, load tokens, wait to settle, read, drain.
// Optional DYNA_TREE_HOST_BOMB_EN: after each job, clear the tree with a BOMB broadcast instead of reset mode.
module dyna_tree_host #(
    parameter int CLR_CYCLES    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_WAIT      = 4096,
    parameter int MAX_TOK       = 64,
    parameter int OUT_DEPTH     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       glob_com,
    dyna_tree_host_if.master bus
);
    localparam logic [1:0] TGT_PARENT   = 2'd0;
    localparam logic [1:0] TGT_CHILDREN = 2'd1;
    localparam logic [3:0] MSG_NONE     = 4'd0;
    localparam logic [3:0] MSG_BUSY     = 4'd1;
    localparam logic [3:0] MSG_BOMB     = 4'd3;
    localparam logic [3:0] MSG_READ     = 4'd4;
    localparam logic [3:0] TOK_EOF      = 4'd7;

    localparam int CNT_TOP = (MAX_WAIT > MAX_TOK)
                           ? ((MAX_WAIT > CLR_CYCLES) ? MAX_WAIT : CLR_CYCLES)
                           : ((MAX_TOK > CLR_CYCLES) ? MAX_TOK : CLR_CYCLES);
    localparam int CW = $clog2(CNT_TOP + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(OUT_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_WAIT, S_READ_CMD,
        S_COLLECT, S_DRAIN, S_DONE, S_BOMB, S_BOMB_CLR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] stab, stab_n;
    logic [3:0]    last_msg, last_msg_n;
    logic [3:0]    msg_q, msg_n;
    logic [1:0]    tgt_q;
    logic [1:0]    glob_com_n;
    logic          busy_n, done_n, error_n, in_ready_q, in_ready_n;

    logic [3:0]    fifo_mem [OUT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_nonempty, accept, sample_ok, push_req, pop, push;

    assign fifo_nonempty = (fifo_cnt != '0);
    assign accept        = bus.in_valid && in_ready_q;
    assign sample_ok     = (bus.from_tree_tgt == TGT_PARENT) &&
                           (bus.from_tree_msg != MSG_NONE) && (bus.from_tree_msg != MSG_BUSY);
    assign push_req      = (state == S_COLLECT) && (bus.from_tree_tgt == TGT_PARENT) &&
                           (bus.from_tree_msg != MSG_NONE) && (bus.from_tree_msg != MSG_READ);
    assign pop           = fifo_nonempty && bus.out_ready;
    // The tree cannot be stalled: a full FIFO only accepts when the head leaves this cycle.
    assign push          = push_req && ((fifo_cnt != (AW+1)'(OUT_DEPTH)) || pop);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        stab_n     = stab;
        last_msg_n = last_msg;
        error_n    = error;
        msg_n      = MSG_NONE;
        unique case (state)
            S_IDLE: if (start) begin
                state_n    = S_CLEAR;
                cnt_n      = '0;
                stab_n     = '0;
                last_msg_n = MSG_NONE;
                error_n    = 1'b0;
            end
            S_CLEAR: if (cnt == CW'(CLR_CYCLES - 1)) begin
                state_n = S_LOAD;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            S_LOAD: if (accept) begin
                msg_n = bus.in_tok;
                if (bus.in_last) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else if (cnt == CW'(MAX_TOK - 1)) begin
                    error_n = 1'b1;
                    state_n = S_DRAIN;
                end else cnt_n = cnt + 1'b1;
            end
            S_WAIT: begin
                if (!sample_ok)                                      stab_n = '0;
                else if (stab != '0 && bus.from_tree_msg == last_msg) stab_n = stab + 1'b1;
                else                                                 stab_n = SW'(1);
                last_msg_n = bus.from_tree_msg;
                if (stab_n == SW'(STABLE_CYCLES)) state_n = S_READ_CMD;
                else if (cnt == CW'(MAX_WAIT - 1)) begin
                    error_n = 1'b1;
                    state_n = S_DONE;
                end else cnt_n = cnt + 1'b1;
            end
            S_READ_CMD: state_n = S_COLLECT;
            S_COLLECT: begin
                if (push_req && !push)                      error_n = 1'b1;
                if (push_req && bus.from_tree_msg == TOK_EOF) state_n = S_DRAIN;
            end
            S_DRAIN: if (!fifo_nonempty) state_n = S_DONE;
`ifdef DYNA_TREE_HOST_BOMB_EN
            S_DONE: state_n = S_BOMB;
            S_BOMB: begin
                state_n = S_BOMB_CLR;
                cnt_n   = '0;
            end
            S_BOMB_CLR: if (cnt == CW'(CLR_CYCLES - 1)) state_n = S_IDLE;
                        else cnt_n = cnt + 1'b1;
`else
            S_DONE: state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_READ_CMD) msg_n = MSG_READ;
`ifdef DYNA_TREE_HOST_BOMB_EN
        if (state_n == S_BOMB)     msg_n = MSG_BOMB;
`endif
        glob_com_n = (state_n == S_IDLE || state_n == S_CLEAR) ? 2'd1 : 2'd0;
        in_ready_n = (state_n == S_LOAD);
        busy_n     = (state_n != S_IDLE);
        done_n     = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stab       <= '0;
            last_msg   <= MSG_NONE;
            msg_q      <= MSG_NONE;
            tgt_q      <= TGT_CHILDREN;
            glob_com   <= 2'd1;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            stab       <= stab_n;
            last_msg   <= last_msg_n;
            msg_q      <= msg_n;
            tgt_q      <= TGT_CHILDREN;
            glob_com   <= glob_com_n;
            in_ready_q <= in_ready_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // NOTE: storage is not reset; the reset occupancy count alone marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.from_tree_msg;
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.to_tree_msg = msg_q;
    assign bus.to_tree_tgt = tgt_q;
    assign bus.out_valid   = fifo_nonempty;
    assign bus.out_tok     = fifo_mem[rd_ptr];
    assign bus.out_last    = fifo_nonempty && (fifo_mem[rd_ptr] == TOK_EOF);
endmodule

// File: tb/tb_dyna_tree_host.sv
// Randomized bench for dyna_tree_host: a root-tree responder plus a job-level reference model
// that predicts loaded tokens, READ count, result stream and error from the job description.
module tb_dyna_tree_host;
    localparam int CLR = 4, STABLE = 8, MAXW = 64, MAXT = 4, DEPTH = 4;
    localparam int EOF_T = 7, READ_M = 4, BUSY_M = 1, JOB_BUDGET = 400;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       busy, done, error;
    logic [1:0] glob_com;

    dyna_tree_host_if bus ();

    dyna_tree_host #(
        .CLR_CYCLES(CLR), .STABLE_CYCLES(STABLE), .MAX_WAIT(MAXW),
        .MAX_TOK(MAXT), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .error(error), .glob_com(glob_com), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // job description
    int tok_q[$];
    bit last_q[$];
    int res_q[$];
    int settle, gap_pct, noise;
    bit hold_out;

    // observations
    int out_q[$];
    bit olast_q[$];
    int loaded_q[$];
    int reads, accepted, done_cyc;
    bit done_seen, done_err;

    int in_set[8]  = '{5, 6, 7, 8, 9, 12, 13, 14};
    int res_set[7] = '{5, 6, 8, 9, 12, 13, 14};

    task automatic idle_drivers();
        bus.in_valid      = 1'b0;
        bus.in_tok        = 4'd0;
        bus.in_last       = 1'b0;
        bus.out_ready     = 1'b0;
        bus.from_tree_msg = 4'd0;
        bus.from_tree_tgt = 2'd0;
    endtask

    task automatic run_job(input bit abort);
        int  idx, ridx, k;
        bit  reading, stop;
        idx = 0; ridx = 0; reading = 0; stop = 0;
        out_q.delete(); olast_q.delete(); loaded_q.delete();
        reads = 0; done_seen = 0; done_cyc = 0; done_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (k = 1; k <= JOB_BUDGET && !stop; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_seen = 1; done_cyc = k; done_err = error; stop = 1;
            end else begin
                if (bus.to_tree_msg == 4'(READ_M)) reads++;
                else if (bus.to_tree_msg != 4'd0) loaded_q.push_back(int'(bus.to_tree_msg));
                // root responder: settle value, then the result list once READ is seen
                if (reading) begin
                    bus.from_tree_tgt = 2'd0;
                    if (ridx < res_q.size()) begin
                        bus.from_tree_msg = 4'(res_q[ridx]);
                        ridx++;
                    end else bus.from_tree_msg = 4'd0;
                end else if (bus.to_tree_msg == 4'(READ_M)) begin
                    reading = 1;
                    bus.from_tree_tgt = 2'd0;
                    bus.from_tree_msg = 4'd0;
                end else if (k <= noise) begin
                    bus.from_tree_tgt = 2'($urandom_range(3));
                    bus.from_tree_msg = 4'($urandom_range(15));
                end else begin
                    bus.from_tree_tgt = 2'd0;
                    bus.from_tree_msg = 4'(settle);
                end
                if (idx < tok_q.size() && $urandom_range(99) >= gap_pct) begin
                    bus.in_valid = 1'b1;
                    bus.in_tok   = 4'(tok_q[idx]);
                    bus.in_last  = last_q[idx];
                end else bus.in_valid = 1'b0;
                if (bus.in_valid && bus.in_ready) idx++;
                if (hold_out) bus.out_ready = reading && ridx >= res_q.size() && bus.from_tree_msg == 4'd0;
                else          bus.out_ready = 1'($urandom_range(1));
                if (bus.out_valid && bus.out_ready) begin
                    out_q.push_back(int'(bus.out_tok));
                    olast_q.push_back(bus.out_last);
                end
                if (abort && reading && ridx == 2) begin
                    #2 rst_n = 1'b0;
                    stop = 1;
                end
            end
        end
        accepted = idx;
        idle_drivers();
        if (!abort && !done_seen) check("done_within_budget", 0, 1);
    endtask

    // Job-level prediction from the rules: tokens up to the first last or MAX_TOK,
    // settle validity, and FIFO retention of the first DEPTH results when the sink is held.
    task automatic check_job(input string name);
        int  n, kept, len;
        bit  found, settle_ok, exp_err;
        int  exp_reads;
        n = 0; found = 0;
        for (int i = 0; i < tok_q.size() && i < MAXT; i++) begin
            n = i + 1;
            if (last_q[i]) begin found = 1; break; end
        end
        settle_ok = (settle != 0) && (settle != BUSY_M);
        len = res_q.size();
        if (!found || !settle_ok) begin
            exp_err = 1; exp_reads = 0; kept = 0;
        end else begin
            exp_reads = 1;
            kept    = (hold_out && len > DEPTH) ? DEPTH : len;
            exp_err = hold_out && len > DEPTH;
        end
        check({name, ".done"}, done_seen, 1);
        check({name, ".error"}, done_err, exp_err);
        check({name, ".reads"}, reads, exp_reads);
        check({name, ".accepted"}, accepted, n);
        check({name, ".loaded_n"}, loaded_q.size(), n);
        for (int i = 0; i < n && i < loaded_q.size(); i++)
            check({name, ".loaded_tok"}, loaded_q[i], tok_q[i]);
        check({name, ".out_n"}, out_q.size(), kept);
        for (int i = 0; i < kept && i < out_q.size(); i++) begin
            check({name, ".out_tok"}, out_q[i], res_q[i]);
            check({name, ".out_last"}, olast_q[i], res_q[i] == EOF_T);
        end
        @(negedge clk);
        check({name, ".done_pulse"}, done, 0);
        for (int i = 0; i < 2 * CLR + 4 && busy; i++) @(negedge clk);
        check({name, ".back_idle"}, busy, 0);
    endtask

    task automatic set_job(input bit hold, input int s, input int gap, input int nz);
        hold_out = hold; settle = s; gap_pct = gap; noise = nz;
    endtask

    initial begin
        idle_drivers();
        tok_q.delete(); last_q.delete(); res_q.delete();
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.error", error, 0);
        check("rst.glob_com", glob_com, 1);
        check("rst.msg", bus.to_tree_msg, 0);
        check("rst.tgt", bus.to_tree_tgt, 1);
        check("rst.in_ready", bus.in_ready, 0);
        check("rst.out_valid", bus.out_valid, 0);
        rst_n = 1'b1;

        // single K0, result is EOF only
        tok_q = '{8}; last_q = '{1}; res_q = '{7};
        set_job(0, 8, 0, 0); run_job(0); check_job("k0");

        // APPLY K0 S0
        tok_q = '{6, 8, 12}; last_q = '{0, 0, 1}; res_q = '{6, 8, 12, 7};
        set_job(0, 6, 0, 0); run_job(0); check_job("apply");

        // root stays BUSY: timeout after MAX_WAIT + CLR_CYCLES + tokens cycles from start
        tok_q = '{8}; last_q = '{1}; res_q = '{7};
        set_job(0, BUSY_M, 0, 0); run_job(0); check_job("timeout");
        check("timeout.cycles", done_cyc, MAXW + CLR + 1 + 1);

        // overflow with sink held: first DEPTH tokens kept
        tok_q = '{8}; last_q = '{1}; res_q = '{6, 8, 12, 9, 13, 14, 7};
        set_job(1, 8, 0, 0); run_job(0); check_job("overflow");

        // too many tokens without last
        tok_q = '{5, 6, 8, 9, 12}; last_q = '{0, 0, 0, 0, 0}; res_q = '{7};
        set_job(0, 8, 0, 0); run_job(0); check_job("too_many");

        // reset during COLLECT
        tok_q = '{8}; last_q = '{1}; res_q = '{6, 8, 12, 7};
        set_job(1, 8, 0, 0); run_job(1);
        #1;
        check("abort.glob_com", glob_com, 1);
        check("abort.out_valid", bus.out_valid, 0);
        check("abort.busy", busy, 0);
        @(negedge clk);
        check("abort.glob_com_held", glob_com, 1);
        check("abort.out_valid_held", bus.out_valid, 0);
        rst_n = 1'b1;
        tok_q = '{8}; last_q = '{1}; res_q = '{6, 8, 7};
        set_job(0, 9, 0, 0); run_job(0); check_job("after_abort");

        for (int j = 0; j < 30; j++) begin
            int ntok, nres;
            bit hold;
            int s;
            tok_q.delete(); last_q.delete(); res_q.delete();
            if ($urandom_range(99) < 80) begin
                ntok = $urandom_range(MAXT, 1);
                for (int i = 0; i < ntok; i++) begin
                    tok_q.push_back(in_set[$urandom_range(7)]);
                    last_q.push_back(i == ntok - 1);
                end
            end else begin
                for (int i = 0; i <= MAXT; i++) begin
                    tok_q.push_back(in_set[$urandom_range(7)]);
                    last_q.push_back(1'b0);
                end
            end
            hold = ($urandom_range(99) < 30);
            nres = hold ? $urandom_range(7) : $urandom_range(DEPTH - 1);
            for (int i = 0; i < nres; i++) res_q.push_back(res_set[$urandom_range(6)]);
            res_q.push_back(EOF_T);
            s = ($urandom_range(99) < 85) ? $urandom_range(15, 2) : $urandom_range(1);
            set_job(hold, s, 30, (s > 1) ? $urandom_range(20) : 0);
            run_job(0);
            check_job("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dyna_tree_host.md
Name: dyna_tree_host

Overview:
- Parent-side initiator for the root port of the dynamic combinator tree: loads a token string into the tree, waits for reduction to settle, then issues a read and drains the result stream to the host.
- Sits between a host token source/sink (valid/ready) and the tree root, whose dataIn/dataOut carry TPort (msg[3:0], tgt[1:0]).
- Drives glob_com for the whole tree.

Parameters:
- CLR_CYCLES, 4: cycles glob_com is held at 1 (reset mode) before loading.
- STABLE_CYCLES, 8: consecutive identical non-busy root replies that count as "settled".
- MAX_WAIT, 4096: settle-wait timeout in cycles.
- MAX_TOK, 64: maximum tokens loaded per job.
- OUT_DEPTH, 16: output FIFO depth, power of 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a job when idle
- busy  out  1  high from the accepted start until return to IDLE
- done  out  1  one-cycle pulse when a job completes, with or without error
- error  out  1  sticky until the next accepted start; set on overflow, timeout or too many tokens
- glob_com  out  2  tree global command: 0 = work, 1 = reset mode
- to_tree_msg  out  4  TPort.msg into the root dataIn
- to_tree_tgt  out  2  TPort.tgt into the root dataIn
- from_tree_msg  in  4  TPort.msg from the root dataOut
- from_tree_tgt  in  2  TPort.tgt from the root dataOut
- in_valid, in_ready  in/out  1  input token handshake
- in_tok  in  4  token kind: EMPTY=0, TRANSIT=5, APPLY=6, EOF=7, K0=8, K1=9, S0=12, S1=13, S2=14
- in_last  in  1  marks the final token of the string
- out_valid, out_ready  out/in  1  result token handshake
- out_tok  out  4  result token
- out_last  out  1  high with the final result token

Behaviour:
- Encodings:
  - tgt: TO_PARENT=0, TO_CHILDREN=1, TO_LEFT=2, TO_RIGHT=3.
  - Meta msg: BUSY=1, READY=2, BOMB=3, READ=4, APPLY=5.
- Reset values: busy=0, done=0, error=0, glob_com=1, to_tree_msg=0, to_tree_tgt=TO_CHILDREN, in_ready=0, out_valid=0, FIFO empty, state IDLE.
- All registered outputs; no combinational path from the input ports to the output ports.
- IDLE:
  - glob_com=1, to_tree_msg=0.
  - start -> CLEAR; clears error and all counters.
  - start in any other state is ignored.
- CLEAR:
  - glob_com=1 for CLR_CYCLES cycles -> LOAD.
- LOAD:
  - glob_com=0, in_ready=1.
  - Each in_valid cycle: to_tree_msg<=in_tok, to_tree_tgt<=TO_CHILDREN, token count++.
  - Cycles without in_valid drive msg 0 (no token).
  - Accepted in_last -> WAIT, next cycle drives msg 0.
  - Count reaching MAX_TOK without in_last: set error, in_ready=0, jump to DRAIN.
- WAIT:
  - Drive msg 0, tgt TO_CHILDREN.
  - A sample is valid when from_tree_tgt==TO_PARENT and from_tree_msg is not 0 and not BUSY.
  - STABLE_CYCLES consecutive valid samples with an identical msg -> READ_CMD.
  - Any change in msg or an invalid sample restarts the stability count.
  - MAX_WAIT cycles elapsed -> set error, go to DONE.
- READ_CMD:
  - One cycle msg=READ, tgt=TO_CHILDREN -> COLLECT.
- COLLECT:
  - Drive msg 0.
  - Each cycle with from_tree_tgt==TO_PARENT and msg not in {0, READ} pushes one token into the FIFO.
  - EOF is pushed with out_last=1 and moves to DRAIN.
  - The tree cannot be stalled. A push while the FIFO is full drops the token and sets error; collection still ends on EOF.
- DRAIN:
  - FIFO empties through out_valid/out_ready.
  - out_tok and out_last present the FIFO head.
  - Once the FIFO is empty -> DONE.
- DONE:
  - done pulse for 1 cycle, then IDLE (or BOMB, see Optional Feature).
- FIFO:
  - Simultaneous push and pop while full is allowed; the pop frees the slot the same cycle.
  - Pointers wrap modulo OUT_DEPTH.
- Asynchronous reset mid-job:
  - Immediate return to the reset values.
  - glob_com=1 puts the tree in reset mode; no partial output is kept.

Optional Feature:
- Macro DYNA_TREE_HOST_BOMB_EN.
- Defined: after DONE, one cycle msg=BOMB, tgt=TO_CHILDREN, then glob_com stays 0 for CLR_CYCLES before IDLE. This clears the tree without reset mode, and busy stays high through it.
- Undefined: DONE -> IDLE directly, and the next job relies on CLEAR.

Test Plan:
- Load [K0(8), in_last] with out_ready=1 -> root settles to 8. Expect READ issued once, then out stream 7 with out_last=1, done pulse, error=0.
- Load [APPLY(6), K0(8), S0(12), last], root model returns 6,8,12,EOF -> out_tok 6,8,12,7, last on 7, done after the FIFO drains.
- Root model holds BUSY(1) forever -> done after MAX_WAIT+CLR_CYCLES+tokens cycles with error=1, out_valid never high.
- OUT_DEPTH=4, out_ready=0, model returns 6 tokens plus EOF -> error=1. First 4 tokens retained in order, then raising out_ready drains exactly those 4.
- MAX_TOK=4, feed 5 tokens without in_last -> in_ready drops after the 4th, error=1, done pulse, no READ issued.
- Assert rst_n low during COLLECT -> next cycle glob_com=1, out_valid=0, busy=0. A subsequent start completes a normal job.
